bt_cmd_parser: RTL and testbench
================================

# bt_cmd_parser

Downstream consumer of the Bluetooth UART receiver: takes each received byte (`rx_data`, qualified by the falling edge of `rx_int`) and assembles 4-byte drive-command frames for the car. Validates header, command code and checksum, then presents a latched direction and speed to the motor-control logic. Includes an inter-byte timeout that resynchronises the parser and a link watchdog that forces the car to stop when valid frames stop arriving.

## Interface
- `BYTE_TO_CYC`, 500_000: inter-byte timeout in clk cycles (10 ms at 50 MHz).
- `TIMEOUT_CYC`, 50_000_000: link-watchdog period in clk cycles (1 s at 50 MHz).
- `SPEED_MAX`, 100: upper clamp for the speed output.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `rx_int`  in  1  receiver busy flag; a 1→0 transition means a byte has completed.
- `rx_data`  in  8  received byte; valid from the cycle `rx_int` is first low.
- `dir`  out  3  0 = stop, 1 = forward, 2 = back, 3 = left, 4 = right.
- `speed`  out  8  drive speed, 0..`SPEED_MAX`.
- `cmd_valid`  out  1  one-cycle pulse when `dir`/`speed` take a new frame.
- `frame_err`  out  1  one-cycle pulse on a bad checksum or an unknown command.
- `link_ok`  out  1  high from the first good frame until the watchdog expires.

## Operation
- Edge detect:
  - Register `rx_int` into `rx_int_d` (reset value 1).
  - `byte_stb = rx_int_d & ~rx_int`.
  - `rx_data` is sampled only in the cycle `byte_stb` is high.
- Frame format: `0xA5`, CMD, SPD, CHK.
  - CHK = (CMD + SPD) mod 256.
- States:
  - IDLE: on strobe, `0xA5` → GET_CMD; any other byte is silently discarded.
  - GET_CMD: on strobe, latch CMD → GET_SPD. `0xA5` here is data, not a resync.
  - GET_SPD: on strobe, latch SPD → GET_CHK.
  - GET_CHK: on strobe → IDLE in all cases.
    - Checksum good and CMD in 0..4: commit the frame.
    - Otherwise: pulse `frame_err`; `dir`, `speed` and `link_ok` are unchanged.
- Commit:
  - `dir` ← CMD.
  - `speed` ← min(SPD, `SPEED_MAX`). If CMD = 0, `speed` ← 0 regardless of SPD.
  - Pulse `cmd_valid`; `link_ok` ← 1; reload the watchdog.
- Inter-byte timer:
  - Clears on every strobe; counts while the state is not IDLE.
  - Reaching `BYTE_TO_CYC`-1 → IDLE, no `frame_err`. The partial frame is dropped.
  - Held at 0 in IDLE.
- Watchdog:
  - Counts every cycle and saturates at `TIMEOUT_CYC`-1.
  - Clears on commit.
  - Reaching `TIMEOUT_CYC`-1 while `link_ok` = 1: `link_ok` ← 0, `dir` ← 0, `speed` ← 0. No `cmd_valid` pulse.
  - The stopped state persists until the next commit.
- Reset (any time, including mid-frame): state IDLE, both counters 0, `dir` = 0, `speed` = 0, `cmd_valid` = 0, `frame_err` = 0, `link_ok` = 0.

## Timing
- Strobe latency: `byte_stb` is high at the first rising edge where `rx_int` = 0 and `rx_int_d` = 1. Exactly one strobe per byte.
- Commit latency: outputs change on the clock edge at which `byte_stb` is high in GET_CHK, so they are visible 1 cycle after `rx_int` is first sampled low. `cmd_valid` is high for that same single cycle.
- `frame_err` follows the same timing as `cmd_valid`. The two never assert together.
- Simultaneous events:
  - Strobe and inter-byte timeout in the same cycle: the strobe wins and the byte is processed.
  - Commit and watchdog expiry in the same cycle: the commit wins, `link_ok` stays 1, the counter reloads.
- Consecutive frames may be back-to-back; no idle gap is required between a CHK byte and the next header.

## Test plan
Use `BYTE_TO_CYC` = 100 and `TIMEOUT_CYC` = 1000.
1. Frame A5 01 32 33 → `dir` = 1, `speed` = 0x32, one `cmd_valid` pulse, `link_ok` = 1, `frame_err` stays 0.
2. Frame A5 02 FF 01 → `dir` = 2, `speed` = 100 (clamped). Frame A5 00 50 50 → `dir` = 0, `speed` = 0.
3. Frame A5 03 10 14 (bad checksum) → `frame_err` pulse, outputs unchanged. Frame A5 07 00 07 (unknown command) → `frame_err` pulse. Leading garbage 12 34 before a valid frame → the valid frame commits normally.
4. Send A5 01, wait 150 cycles, then send a full valid frame → the partial frame is dropped and the new frame commits. A byte strobe landing exactly at cycle 99 of the gap is still accepted.
5. Send a valid forward frame, then no traffic for 1000 cycles → `link_ok` falls, `dir` = 0, `speed` = 0, no `cmd_valid`. The next valid frame restores `link_ok` = 1.
6. Assert `rst` low asynchronously after A5 01 → all outputs return to reset values immediately. After release, the sequence 32 33 alone produces no commit.

Source files
------------

// File: rtl/bt_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// bt_cmd_parser_if
// Groups the byte stream coming from the Bluetooth UART receiver and the drive
// command presented to the motor-control logic.
//   rx_int     receiver busy flag; a 1->0 transition marks a completed byte
//   rx_data    received byte, valid from the cycle rx_int is first low
//   dir        0 stop, 1 forward, 2 back, 3 left, 4 right
//   speed      drive speed, 0..SPEED_MAX
//   cmd_valid  one-cycle pulse when dir/speed take a new frame
//   frame_err  one-cycle pulse on bad checksum or unknown command
//   link_ok    high from the first good frame until the link watchdog expires
// master: byte source / command consumer.  slave: the parser.
// -----------------------------------------------------------------------------
interface bt_cmd_parser_if;
   logic       rx_int;
   logic [7:0] rx_data;
   logic [2:0] dir;
   logic [7:0] speed;
   logic       cmd_valid;
   logic       frame_err;
   logic       link_ok;

   modport master (
      output rx_int, rx_data,
      input  dir, speed, cmd_valid, frame_err, link_ok
   );

   modport slave (
      input  rx_int, rx_data,
      output dir, speed, cmd_valid, frame_err, link_ok
   );
endinterface

// File: rtl/bt_cmd_parser.sv
// -----------------------------------------------------------------------------
// bt_cmd_parser
// Assembles 4-byte drive frames (0xA5, CMD, SPD, CHK) from the UART receiver,
// validates CHK = CMD + SPD (mod 256) and CMD in 0..4, and holds the latest
// good direction/speed.  An inter-byte timer drops stalled partial frames and
// a link watchdog stops the car when good frames stop arriving.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   bt_cmd_parser_if.slave (rx_int/rx_data in; dir, speed, cmd_valid,
//         frame_err, link_ok out)
// -----------------------------------------------------------------------------
module bt_cmd_parser #(
   parameter int BYTE_TO_CYC = 500_000,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int SPEED_MAX   = 100
) (
   input  logic              clk,
   input  logic              rst,
   bt_cmd_parser_if.slave    bus
);

   localparam int BT_W = $clog2(BYTE_TO_CYC);
   localparam int WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TO_CYC - 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [7:0]      HDR     = 8'hA5;

   typedef enum logic [1:0] {IDLE, GET_CMD, GET_SPD, GET_CHK} state_t;

   function automatic logic [7:0] sat_speed(input logic [7:0] s);
      return (s > 8'(SPEED_MAX)) ? 8'(SPEED_MAX) : s;
   endfunction

   state_t          state_q, state_d;
   logic            rx_int_q;
   logic [BT_W-1:0] bt_q, bt_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [2:0]      dir_q, dir_d;
   logic [7:0]      speed_q, speed_d;
   logic            cv_q, cv_d;
   logic            fe_q, fe_d;
   logic            link_q, link_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      spd_q, spd_d;
   logic            byte_stb;
   logic            commit;
   logic [7:0]      sum;

   always_comb begin
      byte_stb = rx_int_q & ~bus.rx_int;
      sum      = cmd_q + spd_q;
      commit   = 1'b0;
      state_d  = state_q;
      bt_d     = bt_q;
      dir_d    = dir_q;
      speed_d  = speed_q;
      link_d   = link_q;
      cv_d     = 1'b0;
      fe_d     = 1'b0;
      cmd_d    = cmd_q;
      spd_d    = spd_q;
      // Watchdog free-runs and sticks at its terminal count.
      wd_d     = (wd_q == WD_LAST) ? wd_q : wd_q + WD_W'(1);

      // A strobe always beats the inter-byte timeout in the same cycle.
      if (byte_stb) begin
         bt_d = '0;
         case (state_q)
            IDLE:    if (bus.rx_data == HDR) state_d = GET_CMD;
            GET_CMD: begin cmd_d = bus.rx_data; state_d = GET_SPD; end
            GET_SPD: begin spd_d = bus.rx_data; state_d = GET_CHK; end
            GET_CHK: begin
               state_d = IDLE;
               if (sum == bus.rx_data && cmd_q <= 8'd4) commit = 1'b1;
               else                                      fe_d   = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE) begin
         if (bt_q == BT_LAST) begin
            state_d = IDLE;
            bt_d    = '0;
         end else begin
            bt_d = bt_q + BT_W'(1);
         end
      end

      // Commit has priority over a watchdog expiry landing on the same edge.
      if (commit) begin
         dir_d   = cmd_q[2:0];
         speed_d = (cmd_q == 8'd0) ? 8'd0 : sat_speed(spd_q);
         cv_d    = 1'b1;
         link_d  = 1'b1;
         wd_d    = '0;
      end else if (link_q && wd_q == WD_LAST) begin
         link_d  = 1'b0;
         dir_d   = 3'd0;
         speed_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rx_int_q <= 1'b1;
         bt_q     <= '0;
         wd_q     <= '0;
         dir_q    <= 3'd0;
         speed_q  <= 8'd0;
         cv_q     <= 1'b0;
         fe_q     <= 1'b0;
         link_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_int_q <= bus.rx_int;
         bt_q     <= bt_d;
         wd_q     <= wd_d;
         dir_q    <= dir_d;
         speed_q  <= speed_d;
         cv_q     <= cv_d;
         fe_q     <= fe_d;
         link_q   <= link_d;
      end
   end

   // Frame field holding registers are only read after being written in the
   // current frame, so they carry no reset.
   always_ff @(posedge clk) begin
      cmd_q <= cmd_d;
      spd_q <= spd_d;
   end

   assign bus.dir       = dir_q;
   assign bus.speed     = speed_q;
   assign bus.cmd_valid = cv_q;
   assign bus.frame_err = fe_q;
   assign bus.link_ok   = link_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
module tb_bt_cmd_parser;
   localparam int BYTE_TO_CYC = 100;
   localparam int TIMEOUT_CYC = 1000;
   localparam int SPEED_MAX   = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bt_cmd_parser_if bus();

   bt_cmd_parser #(
      .BYTE_TO_CYC(BYTE_TO_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC),
      .SPEED_MAX  (SPEED_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   int cv_cnt   = 0;
   int fe_cnt   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // Frame-level view: a queue of the bytes of the frame being collected,
   // the cycle of the last accepted byte and the cycle of the last commit.
   logic [7:0] fq[$];
   longint     cyc = 0, last_byte = 0, last_commit = 0;
   bit         m_prev = 1'b1;
   int         m_dir = 0, m_spd = 0;
   bit         m_cv = 0, m_fe = 0, m_link = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_prev = 1'b1;
         fq.delete();
         m_dir = 0; m_spd = 0; m_cv = 0; m_fe = 0; m_link = 0;
      end else begin
         bit stb, commit;
         cyc++;
         stb    = m_prev && !bus.rx_int;
         m_prev = bus.rx_int;
         m_cv = 0; m_fe = 0; commit = 0;
         if (stb) begin
            last_byte = cyc;
            if (fq.size() == 0) begin
               if (bus.rx_data == 8'hA5) fq.push_back(bus.rx_data);
            end else begin
               fq.push_back(bus.rx_data);
               if (fq.size() == 4) begin
                  if ((int'(fq[1]) + int'(fq[2])) % 256 == int'(fq[3]) && int'(fq[1]) <= 4) begin
                     commit = 1;
                     m_dir  = int'(fq[1]);
                     m_spd  = (m_dir == 0) ? 0 : ((int'(fq[2]) > SPEED_MAX) ? SPEED_MAX : int'(fq[2]));
                     m_cv   = 1;
                     m_link = 1;
                  end else begin
                     m_fe = 1;
                  end
                  fq.delete();
               end
            end
         end else if (fq.size() != 0 && cyc - last_byte >= BYTE_TO_CYC) begin
            fq.delete();
         end
         if (commit) last_commit = cyc;
         else if (m_link && cyc - last_commit >= TIMEOUT_CYC) begin
            m_link = 0; m_dir = 0; m_spd = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en && rst) begin
         chk("dir",       32'(bus.dir),       32'(m_dir));
         chk("speed",     32'(bus.speed),     32'(m_spd));
         chk("cmd_valid", 32'(bus.cmd_valid), 32'(m_cv));
         chk("frame_err", 32'(bus.frame_err), 32'(m_fe));
         chk("link_ok",   32'(bus.link_ok),   32'(m_link));
         if (bus.cmd_valid) cv_cnt++;
         if (bus.frame_err) fe_cnt++;
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called at a negedge; the strobe lands on the posedge after rx_int drops,
   // so strobe spacing between consecutive calls is low(prev) + busy(next).
   task automatic send_byte(input logic [7:0] b, input int busy, input int low);
      bus.rx_int  = 1'b1;
      bus.rx_data = 8'($urandom);
      repeat (busy) @(negedge clk);
      bus.rx_int  = 1'b0;
      bus.rx_data = b;
      repeat (low) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] s, input logic [7:0] k);
      send_byte(8'hA5, $urandom_range(1, 4), $urandom_range(1, 4));
      send_byte(c,     $urandom_range(1, 4), $urandom_range(1, 4));
      send_byte(s,     $urandom_range(1, 4), $urandom_range(1, 4));
      send_byte(k,     $urandom_range(1, 4), $urandom_range(1, 4));
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   task automatic pin(input string tag, input int d, input int s, input bit l);
      chk({tag, "_dir"},   32'(bus.dir),     32'(d));
      chk({tag, "_speed"}, 32'(bus.speed),   32'(s));
      chk({tag, "_link"},  32'(bus.link_ok), 32'(l));
   endtask

   initial begin
      int cv0, fe0;
      bus.rx_int  = 1'b1;
      bus.rx_data = 8'h00;
      #2 rst = 1'b0;
      #1;
      pin("reset", 0, 0, 0);
      chk("reset_cv", 32'(bus.cmd_valid), 32'd0);
      chk("reset_fe", 32'(bus.frame_err), 32'd0);
      repeat (3) @(negedge clk);
      rst    = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      // 1: basic forward frame
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h01, 8'h32, 8'h33); settle();
      pin("t1", 1, 8'h32, 1);
      chk("t1_cv_pulses", 32'(cv_cnt - cv0), 32'd1);
      chk("t1_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

      // 2: clamp and stop
      send_frame(8'h02, 8'hFF, 8'h01); settle();
      pin("t2a", 2, 100, 1);
      send_frame(8'h00, 8'h50, 8'h50); settle();
      pin("t2b", 0, 0, 1);

      // 3: bad checksum, unknown command, leading garbage
      send_frame(8'h02, 8'h20, 8'h22); settle();
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h03, 8'h10, 8'h14); settle();
      pin("t3a", 2, 8'h20, 1);
      send_frame(8'h07, 8'h00, 8'h07); settle();
      pin("t3b", 2, 8'h20, 1);
      chk("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd2);
      chk("t3_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
      send_byte(8'h12, 2, 2); send_byte(8'h34, 2, 2);
      send_frame(8'h04, 8'h09, 8'h0D); settle();
      pin("t3c", 4, 9, 1);

      // 4: stalled partial frame dropped; gap of exactly 100 accepted, 101 not
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_byte(8'hA5, 2, 2); send_byte(8'h01, 2, 150);
      send_frame(8'h02, 8'h20, 8'h22); settle();
      pin("t4a", 2, 8'h20, 1);
      send_byte(8'hA5, 2, 2); send_byte(8'h03, 2, 50);
      send_byte(8'h40, 50, 50); send_byte(8'h43, 50, 3); settle();
      pin("t4b", 3, 8'h40, 1);
      send_byte(8'hA5, 2, 2); send_byte(8'h04, 2, 50);
      send_byte(8'h10, 51, 3); send_byte(8'h14, 2, 3); settle();
      pin("t4c", 3, 8'h40, 1);
      chk("t4_cv_pulses", 32'(cv_cnt - cv0), 32'd2);
      chk("t4_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

      // 5: watchdog expiry, then a commit landing on the expiry edge
      send_frame(8'h01, 8'h32, 8'h33);
      cv0 = cv_cnt;
      repeat (1010) @(negedge clk); #1;
      pin("t5a", 0, 0, 0);
      chk("t5_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
      send_frame(8'h01, 8'h10, 8'h11); settle();
      pin("t5b", 1, 8'h10, 1);
      send_byte(8'hA5, 2, 2); send_byte(8'h01, 2, 2);
      send_byte(8'h10, 2, 2); send_byte(8'h11, 2, 350);
      send_byte(8'hA5, 350, 50); send_byte(8'h02, 50, 50);
      send_byte(8'h05, 50, 50); send_byte(8'h07, 50, 5); #1;
      pin("t5c", 2, 5, 1);

      // 6: asynchronous reset mid-frame
      send_frame(8'h01, 8'h32, 8'h33); settle();
      send_byte(8'hA5, 2, 2); send_byte(8'h01, 2, 3);
      #2;
      rst = 1'b0;
      bus.rx_int = 1'b1;
      #1;
      pin("t6a", 0, 0, 0);
      chk("t6_cv", 32'(bus.cmd_valid), 32'd0);
      chk("t6_fe", 32'(bus.frame_err), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_byte(8'h32, 2, 3); send_byte(8'h33, 2, 3); settle();
      pin("t6b", 0, 0, 0);
      chk("t6_cv_pulses", 32'(cv_cnt - cv0), 32'd0);
      chk("t6_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

      // Randomized traffic checked cycle-by-cycle against the model
      for (int i = 0; i < 150; i++) begin
         int kind;
         logic [7:0] c, s;
         kind = $urandom_range(0, 9);
         c = 8'($urandom_range(0, 4));
         s = 8'($urandom);
         case (kind)
            0, 1, 2, 3: send_frame(c, s, c + s);
            4:          send_frame(c, s, c + s + 8'($urandom_range(1, 255)));
            5: begin
               c = 8'($urandom_range(5, 255));
               send_frame(c, s, c + s);
            end
            6: send_byte(8'($urandom_range(0, 8'hA4)), $urandom_range(1, 4), $urandom_range(1, 4));
            7: begin
               send_byte(8'hA5, $urandom_range(1, 4), $urandom_range(1, 4));
               send_byte(c, $urandom_range(1, 4), $urandom_range(94, 100));
               send_byte(s, $urandom_range(1, 6), $urandom_range(1, 4));
               send_byte(c + s, $urandom_range(1, 4), $urandom_range(1, 4));
            end
            8: repeat ($urandom_range(990, 1010)) @(negedge clk);
            default: send_frame(c, s, c + s);
         endcase
      end
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
